// File: rtl/rc4_pkg.sv
// Shared types, constants and helpers for the RC4 decryption engine.
package rc4_pkg;

    typedef enum logic [2:0] {StIdle, StInit, StKsa, StPrga, StDone} state_e;

    // PhIdle marks "no sub-phase active"; A..F belong to the swap unit, G/H to the top.
    typedef enum logic [3:0] {PhIdle, PhA, PhB, PhC, PhD, PhE, PhF, PhG, PhH} phase_e;

    localparam int unsigned S_SIZE      = 256;
    localparam logic [7:0]  ASCII_SPACE = 8'h20;
    localparam logic [7:0]  ASCII_LO    = 8'h61;
    localparam logic [7:0]  ASCII_HI    = 8'h7A;

    function automatic logic is_printable(input logic [7:0] b);
        return (b == ASCII_SPACE) || ((b >= ASCII_LO) && (b <= ASCII_HI));
    endfunction

endpackage

// File: rtl/rc4_swap_unit.sv
// Six-cycle read-S[i] / read-S[j] / swap sequencer shared by KSA and PRGA.
module rc4_swap_unit
    import rc4_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go_i,
    input  logic       clear_j_i,
    input  logic [7:0] i_i,
    input  logic [7:0] j_inc_i,
    input  logic [7:0] s_rdata_i,
    output logic [7:0] s_addr_o,
    output logic [7:0] s_wdata_o,
    output logic       s_wr_en_o,
    output logic [7:0] si_o,
    output logic [7:0] sj_o,
    output logic       swap_done_o
);

    phase_e     phase_q, phase_d;
    logic [7:0] j_q, j_d;
    logic [7:0] si_q, si_d;
    logic [7:0] sj_q, sj_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= PhIdle;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
        end else begin
            phase_q <= phase_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        unique case (phase_q)
            PhA: phase_d = PhB;
            PhB: begin
                phase_d = PhC;
                si_d    = s_rdata_i;
                j_d     = j_q + s_rdata_i + j_inc_i;
            end
            PhC: phase_d = PhD;
            PhD: begin
                phase_d = PhE;
                sj_d    = s_rdata_i;
            end
            PhE: phase_d = PhF;
            default: phase_d = PhIdle;
        endcase
        // go in F chains the next iteration back-to-back
        if (go_i) phase_d = PhA;
        if (clear_j_i) j_d = '0;
    end

    always_comb begin
        s_addr_o    = '0;
        s_wdata_o   = '0;
        s_wr_en_o   = 1'b0;
        swap_done_o = (phase_q == PhF);
        si_o        = si_q;
        sj_o        = sj_q;
        case (phase_q)
            PhA: s_addr_o = i_i;
            PhC: s_addr_o = j_q;
            PhE: begin
                s_addr_o  = j_q;
                s_wdata_o = si_q;
                s_wr_en_o = 1'b1;
            end
            PhF: begin
                s_addr_o  = i_i;
                s_wdata_o = sj_q;
                s_wr_en_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rc4_engine.sv
// RC4 decryption engine: S init, key scheduling and keystream XOR with an optional
// printable-plaintext early abort, driving external S, ciphertext and plaintext memories.
module rc4_engine
    import rc4_pkg::*;
#(
    parameter int unsigned KEY_BYTES       = 3,
    parameter int unsigned MSG_LEN         = 32,
    parameter int unsigned CHECK_PRINTABLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    output logic [7:0]             s_addr,
    output logic [7:0]             s_wdata,
    output logic                   s_wr_en,
    input  logic [7:0]             s_rdata,
    output logic [7:0]             enc_addr,
    input  logic [7:0]             enc_rdata,
    output logic [7:0]             dec_addr,
    output logic [7:0]             dec_wdata,
    output logic                   dec_wr_en,
    output logic                   busy,
    output logic                   done,
    output logic                   key_ok
);

    state_e                 state_q, state_d;
    phase_e                 ph_q, ph_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [3:0]             kidx_q, kidx_d;
    logic [8*KEY_BYTES-1:0] key_q, key_d;
    logic                   key_ok_q, key_ok_d;

    logic       go, clear_j, swap_done;
    logic [7:0] swap_i, j_inc, key_byte, plain;
    logic [7:0] sw_addr, sw_wdata, si, sj;
    logic       sw_wr_en;

    assign plain  = s_rdata ^ enc_rdata;
    assign swap_i = (state_q == StPrga) ? cnt_q + 8'd1 : cnt_q;
    assign j_inc  = (state_q == StKsa) ? key_byte : 8'd0;

    always_comb begin
        key_byte = '0;
        for (int unsigned n = 0; n < KEY_BYTES; n++) begin
            if (kidx_q == 4'(n)) key_byte = key_q[8*(KEY_BYTES-1-n) +: 8];
        end
    end

    rc4_swap_unit u_swap (
        .clk         (clk),
        .rst_n       (rst_n),
        .go_i        (go),
        .clear_j_i   (clear_j),
        .i_i         (swap_i),
        .j_inc_i     (j_inc),
        .s_rdata_i   (s_rdata),
        .s_addr_o    (sw_addr),
        .s_wdata_o   (sw_wdata),
        .s_wr_en_o   (sw_wr_en),
        .si_o        (si),
        .sj_o        (sj),
        .swap_done_o (swap_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            ph_q     <= PhIdle;
            cnt_q    <= '0;
            kidx_q   <= '0;
            key_q    <= '0;
            key_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            cnt_q    <= cnt_d;
            kidx_q   <= kidx_d;
            key_q    <= key_d;
            key_ok_q <= key_ok_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        cnt_d    = cnt_q;
        kidx_d   = kidx_q;
        key_d    = key_q;
        key_ok_d = key_ok_q;
        go       = 1'b0;
        clear_j  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StInit;
                    cnt_d    = '0;
                    kidx_d   = '0;
                    key_d    = secret_key;
                    key_ok_d = 1'b0;
                end
            end
            StInit: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'(S_SIZE - 1)) begin
                    state_d = StKsa;
                    go      = 1'b1;
                    clear_j = 1'b1;
                end
            end
            StKsa: begin
                if (swap_done) begin
                    cnt_d  = cnt_q + 8'd1;
                    kidx_d = (kidx_q == 4'(KEY_BYTES - 1)) ? 4'd0 : kidx_q + 4'd1;
                    go     = 1'b1;
                    if (cnt_q == 8'(S_SIZE - 1)) begin
                        state_d = StPrga;
                        clear_j = 1'b1;
                    end
                end
            end
            StPrga: begin
                unique case (ph_q)
                    PhG: ph_d = PhH;
                    PhH: begin
                        ph_d = PhIdle;
                        if ((CHECK_PRINTABLE != 0) && !is_printable(plain)) begin
                            state_d  = StDone;
                            key_ok_d = 1'b0;
                        end else if (cnt_q == 8'(MSG_LEN - 1)) begin
                            state_d  = StDone;
                            key_ok_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                            go    = 1'b1;
                        end
                    end
                    default: if (swap_done) ph_d = PhG;
                endcase
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        s_addr    = '0;
        s_wdata   = '0;
        s_wr_en   = 1'b0;
        enc_addr  = '0;
        dec_addr  = '0;
        dec_wdata = '0;
        dec_wr_en = 1'b0;
        busy      = (state_q == StInit) || (state_q == StKsa) || (state_q == StPrga);
        done      = (state_q == StDone);
        key_ok    = key_ok_q;
        case (state_q)
            StInit: begin
                s_addr  = cnt_q;
                s_wdata = cnt_q;
                s_wr_en = 1'b1;
            end
            StKsa: begin
                s_addr  = sw_addr;
                s_wdata = sw_wdata;
                s_wr_en = sw_wr_en;
            end
            StPrga: begin
                s_addr   = (ph_q == PhG) ? si + sj : sw_addr;
                s_wdata  = sw_wdata;
                s_wr_en  = sw_wr_en;
                enc_addr = cnt_q;
                // Read data only arrives in H, so the XOR feeds the write data directly.
                if (ph_q == PhH) begin
                    dec_addr  = cnt_q;
                    dec_wdata = plain;
                    dec_wr_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
